// File: rtl/game_tick_scheduler.sv
// Motion-timing sequencer: derives ball and paddle step enables from the base tick and runs the serve/run/pause game flow.
// Optional demo rally while idle: define TICK_SCHED_ATTRACT_EN.
module game_tick_scheduler #(
    parameter int DIV_W         = 8,
    parameter int BALL_DIV_INIT = 16,
    parameter int BALL_DIV_MIN  = 4,
    parameter int BALL_DIV_STEP = 2,
    parameter int PADDLE_DIV    = 4,
    parameter int SPEEDUP_HITS  = 4,
    parameter int SERVE_TICKS   = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             BaseTick,
    input  logic             Start,
    input  logic             Pause,
    input  logic             Hit,
    input  logic             Miss,
    output logic             BallTick,
    output logic             PaddleTick,
    output logic             Running,
    output logic             Serving,
    output logic [3:0]       Level,
    output logic [DIV_W-1:0] BallDiv
);

    localparam int SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam int HIT_W   = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

    localparam logic [DIV_W-1:0]   DIV_ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0]   BALL_INIT_V  = DIV_W'(BALL_DIV_INIT);
    localparam logic [DIV_W-1:0]   BALL_INIT_M1 = DIV_W'(BALL_DIV_INIT - 1);
    localparam logic [DIV_W:0]     BALL_FLOOR_X = (DIV_W + 1)'(BALL_DIV_MIN + BALL_DIV_STEP);
    localparam logic [DIV_W-1:0]   BALL_MIN_V   = DIV_W'(BALL_DIV_MIN);
    localparam logic [DIV_W-1:0]   BALL_STEP_V  = DIV_W'(BALL_DIV_STEP);
    localparam logic [DIV_W-1:0]   PAD_M1       = DIV_W'(PADDLE_DIV - 1);
    localparam logic [SERVE_W-1:0] SERVE_LAST   = SERVE_W'(SERVE_TICKS - 1);
    localparam logic [SERVE_W-1:0] SERVE_ONE    = SERVE_W'(1);
    localparam logic [HIT_W-1:0]   HIT_LAST     = HIT_W'(SPEEDUP_HITS - 1);
    localparam logic [HIT_W-1:0]   HIT_ONE      = HIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE,
        ST_RUN,
        ST_PAUSED
    } state_t;

    state_t             state_reg,     state_next;
    logic [SERVE_W-1:0] serve_cnt_reg, serve_cnt_next;
    logic [HIT_W-1:0]   hit_cnt_reg,   hit_cnt_next;
    logic [3:0]         level_reg,     level_next;
    logic [DIV_W-1:0]   ball_div_reg,  ball_div_next;
    logic [DIV_W-1:0]   ball_cnt_reg,  ball_cnt_next;
    logic [DIV_W-1:0]   pad_cnt_reg,   pad_cnt_next;
    logic               ball_tick_reg, ball_tick_next;
    logic               pad_tick_reg,  pad_tick_next;
    logic               running_reg,   running_next;
    logic               serving_reg,   serving_next;

    logic               enter_serve;
    logic               ball_adv;
    logic               pad_adv;
    logic [DIV_W-1:0]   ball_reload_div;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            serve_cnt_reg <= '0;
            hit_cnt_reg   <= '0;
            level_reg     <= 4'd0;
            ball_div_reg  <= BALL_INIT_V;
            ball_cnt_reg  <= BALL_INIT_M1;
            pad_cnt_reg   <= PAD_M1;
            ball_tick_reg <= 1'b0;
            pad_tick_reg  <= 1'b0;
            running_reg   <= 1'b0;
            serving_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            serve_cnt_reg <= serve_cnt_next;
            hit_cnt_reg   <= hit_cnt_next;
            level_reg     <= level_next;
            ball_div_reg  <= ball_div_next;
            ball_cnt_reg  <= ball_cnt_next;
            pad_cnt_reg   <= pad_cnt_next;
            ball_tick_reg <= ball_tick_next;
            pad_tick_reg  <= pad_tick_next;
            running_reg   <= running_next;
            serving_reg   <= serving_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        serve_cnt_next  = serve_cnt_reg;
        hit_cnt_next    = hit_cnt_reg;
        level_next      = level_reg;
        ball_div_next   = ball_div_reg;
        ball_cnt_next   = ball_cnt_reg;
        pad_cnt_next    = pad_cnt_reg;
        ball_tick_next  = 1'b0;
        pad_tick_next   = 1'b0;
        enter_serve     = 1'b0;
        ball_adv        = 1'b0;
        pad_adv         = 1'b0;
        ball_reload_div = ball_div_reg;

        case (state_reg)
            ST_IDLE: begin
`ifdef TICK_SCHED_ATTRACT_EN
                ball_adv        = BaseTick;
                pad_adv         = BaseTick;
                ball_reload_div = BALL_INIT_V;
`endif
                if (Start) begin
                    state_next  = ST_SERVE;
                    enter_serve = 1'b1;
                end
            end
            ST_SERVE: begin
                pad_adv = BaseTick;
                if (BaseTick) begin
                    if (serve_cnt_reg == SERVE_LAST) begin
                        state_next = ST_RUN;
                    end else begin
                        serve_cnt_next = serve_cnt_reg + SERVE_ONE;
                    end
                end
            end
            ST_RUN: begin
                ball_adv = BaseTick;
                pad_adv  = BaseTick;
                if (Miss) begin
                    state_next  = ST_SERVE;
                    enter_serve = 1'b1;
                end else begin
                    if (Hit) begin
                        if (hit_cnt_reg == HIT_LAST) begin
                            hit_cnt_next = '0;
                            if (level_reg != 4'd15) begin
                                level_next = level_reg + 4'd1;
                            end
                            // Compare first so the divisor never wraps below the floor.
                            if ({1'b0, ball_div_reg} >= BALL_FLOOR_X) begin
                                ball_div_next = ball_div_reg - BALL_STEP_V;
                            end else begin
                                ball_div_next = BALL_MIN_V;
                            end
                        end else begin
                            hit_cnt_next = hit_cnt_reg + HIT_ONE;
                        end
                    end
                    if (Pause) begin
                        state_next = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (!Pause) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A reload picks up the divisor in force before this cycle's hit.
        if (ball_adv) begin
            if (ball_cnt_reg == '0) begin
                ball_tick_next = 1'b1;
                ball_cnt_next  = ball_reload_div - DIV_ONE;
            end else begin
                ball_cnt_next  = ball_cnt_reg - DIV_ONE;
            end
        end

        if (pad_adv) begin
            if (pad_cnt_reg == '0) begin
                pad_tick_next = 1'b1;
                pad_cnt_next  = PAD_M1;
            end else begin
                pad_cnt_next  = pad_cnt_reg - DIV_ONE;
            end
        end

        // Serve entry rewinds the rally; the paddle cadence is left alone.
        if (enter_serve) begin
            serve_cnt_next = '0;
            hit_cnt_next   = '0;
            level_next     = 4'd0;
            ball_div_next  = BALL_INIT_V;
            ball_cnt_next  = BALL_INIT_M1;
        end

        running_next = (state_next == ST_RUN);
        serving_next = (state_next == ST_SERVE);
    end

    assign BallTick   = ball_tick_reg;
    assign PaddleTick = pad_tick_reg;
    assign Running    = running_reg;
    assign Serving    = serving_reg;
    assign Level      = level_reg;
    assign BallDiv    = ball_div_reg;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: vector table, directed timing sequences, then random stimulus against a tick-counting model.
module tb_game_tick_scheduler;

    localparam int DIV_W         = 8;
    localparam int BALL_DIV_INIT = 16;
    localparam int BALL_DIV_MIN  = 4;
    localparam int BALL_DIV_STEP = 2;
    localparam int PADDLE_DIV    = 4;
    localparam int SPEEDUP_HITS  = 4;
    localparam int SERVE_TICKS   = 32;

    localparam int M_IDLE   = 0;
    localparam int M_SERVE  = 1;
    localparam int M_RUN    = 2;
    localparam int M_PAUSED = 3;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             BaseTick = 1'b0;
    logic             Start = 1'b0;
    logic             Pause = 1'b0;
    logic             Hit = 1'b0;
    logic             Miss = 1'b0;
    logic             BallTick;
    logic             PaddleTick;
    logic             Running;
    logic             Serving;
    logic [3:0]       Level;
    logic [DIV_W-1:0] BallDiv;

    int checks = 0;
    int errors = 0;
    bit cmp_model = 1'b0;

    // Reference model: counts base ticks elapsed toward the next step.
    int m_state    = M_IDLE;
    int m_serve    = 0;
    int m_hits     = 0;
    int m_level    = 0;
    int m_div      = BALL_DIV_INIT;
    int m_ball_el  = 0;
    int m_ball_per = BALL_DIV_INIT;
    int m_pad_el   = 0;
    int m_btick    = 0;
    int m_ptick    = 0;

    game_tick_scheduler #(
        .DIV_W(DIV_W), .BALL_DIV_INIT(BALL_DIV_INIT), .BALL_DIV_MIN(BALL_DIV_MIN),
        .BALL_DIV_STEP(BALL_DIV_STEP), .PADDLE_DIV(PADDLE_DIV),
        .SPEEDUP_HITS(SPEEDUP_HITS), .SERVE_TICKS(SERVE_TICKS)
    ) dut (
        .Clock(Clock), .Reset(Reset), .BaseTick(BaseTick), .Start(Start),
        .Pause(Pause), .Hit(Hit), .Miss(Miss), .BallTick(BallTick),
        .PaddleTick(PaddleTick), .Running(Running), .Serving(Serving),
        .Level(Level), .BallDiv(BallDiv)
    );

    always #5 Clock = ~Clock;

    task automatic model_step(input logic rst, st, pa, hi, mi, bt);
        int  nxt;
        bit  enter;
        bit  ball_runs;
        bit  pad_runs;
        m_btick = 0;
        m_ptick = 0;
        if (rst) begin
            m_state = M_IDLE; m_serve = 0; m_hits = 0; m_level = 0;
            m_div = BALL_DIV_INIT; m_ball_el = 0; m_ball_per = BALL_DIV_INIT; m_pad_el = 0;
        end else begin
            nxt = m_state;
            enter = 1'b0;
            ball_runs = bt && (m_state == M_RUN);
            pad_runs  = bt && (m_state == M_RUN || m_state == M_SERVE);
`ifdef TICK_SCHED_ATTRACT_EN
            if (m_state == M_IDLE) begin
                ball_runs = bt;
                pad_runs  = bt;
            end
`endif
            if (ball_runs) begin
                m_ball_el++;
                if (m_ball_el == m_ball_per) begin
                    m_btick = 1;
                    m_ball_el = 0;
                    m_ball_per = m_div;
                end
            end
            if (pad_runs) begin
                m_pad_el++;
                if (m_pad_el == PADDLE_DIV) begin
                    m_ptick = 1;
                    m_pad_el = 0;
                end
            end
            case (m_state)
                M_IDLE:   if (st) enter = 1'b1;
                M_SERVE:  if (bt) begin
                              if (m_serve == SERVE_TICKS - 1) nxt = M_RUN;
                              m_serve++;
                          end
                M_RUN:    if (mi) enter = 1'b1;
                          else begin
                              if (hi) begin
                                  m_hits++;
                                  if (m_hits == SPEEDUP_HITS) begin
                                      m_hits = 0;
                                      m_level = (m_level + 1 > 15) ? 15 : m_level + 1;
                                      m_div = (m_div - BALL_DIV_STEP < BALL_DIV_MIN) ? BALL_DIV_MIN
                                                                                      : m_div - BALL_DIV_STEP;
                                  end
                              end
                              if (pa) nxt = M_PAUSED;
                          end
                default:  if (!pa) nxt = M_RUN;
            endcase
            if (enter) begin
                nxt = M_SERVE; m_serve = 0; m_div = BALL_DIV_INIT; m_level = 0; m_hits = 0;
                m_ball_el = 0; m_ball_per = BALL_DIV_INIT;
            end
            m_state = nxt;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // One clock with the given inputs held; outputs are examined 1 ns after the edge.
    task automatic cyc(input logic rst, st, pa, hi, mi, bt);
        int exp_v;
        int act_v;
        Reset = rst; Start = st; Pause = pa; Hit = hi; Miss = mi; BaseTick = bt;
        @(posedge Clock);
        model_step(rst, st, pa, hi, mi, bt);
        #1;
        if (cmp_model) begin
            exp_v = {m_btick[0], m_ptick[0], m_state == M_RUN, m_state == M_SERVE, m_level[3:0], m_div[7:0]};
            act_v = {BallTick, PaddleTick, Running, Serving, Level, BallDiv};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model t=%0t: got bt=%0b pt=%0b run=%0b srv=%0b lvl=%0d div=%0d expected bt=%0d pt=%0d run=%0b srv=%0b lvl=%0d div=%0d",
                         $time, BallTick, PaddleTick, Running, Serving, Level, BallDiv,
                         m_btick, m_ptick, m_state == M_RUN, m_state == M_SERVE, m_level, m_div);
            end
        end
    endtask

    // One base tick followed by three idle clocks; returns tick pulses seen.
    task automatic grp(input logic pa, output int bn, output int pn);
        bn = 0;
        pn = 0;
        cyc(1'b0, 1'b0, pa, 1'b0, 1'b0, 1'b1);
        bn += int'(BallTick);
        pn += int'(PaddleTick);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, pa, 1'b0, 1'b0, 1'b0);
            bn += int'(BallTick);
            pn += int'(PaddleTick);
        end
    endtask

    task automatic groups_to_ball(output int n);
        int bn;
        int pn;
        n = -1;
        for (int g = 1; g <= 64; g++) begin
            grp(1'b0, bn, pn);
            if (bn != 0) begin
                n = g;
                break;
            end
        end
    endtask

    task automatic hits(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fast_to_run();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < SERVE_TICKS; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic rst, st, pa, hi, mi, bt;
        int   n;
        int   e_run, e_srv, e_lvl, e_div;
    } vec_t;

    vec_t vt[14];

    initial begin
        int bn, pn, btot, ptot, n, serve_drop;

        vt[0]  = '{1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 16};
        vt[1]  = '{0, 0, 0, 0, 0, 1,  5, 0, 0, 0, 16};
        vt[2]  = '{0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 16};
        vt[3]  = '{0, 0, 0, 0, 0, 1, 31, 0, 1, 0, 16};
        vt[4]  = '{0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 16};
        vt[5]  = '{0, 0, 0, 1, 0, 0,  4, 1, 0, 1, 14};
        vt[6]  = '{0, 0, 0, 1, 0, 0,  4, 1, 0, 2, 12};
        vt[7]  = '{0, 0, 1, 0, 0, 0,  3, 0, 0, 2, 12};
        vt[8]  = '{0, 0, 1, 0, 1, 0,  1, 0, 0, 2, 12};
        vt[9]  = '{0, 0, 0, 0, 0, 0,  1, 1, 0, 2, 12};
        vt[10] = '{0, 0, 0, 1, 1, 0,  1, 0, 1, 0, 16};
        vt[11] = '{0, 0, 1, 0, 0, 1,  3, 0, 1, 0, 16};
        vt[12] = '{1, 1, 0, 0, 0, 1,  1, 0, 0, 0, 16};
        vt[13] = '{0, 1, 0, 0, 1, 0,  2, 0, 1, 0, 16};

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < vt[i].n; r++)
                cyc(vt[i].rst, vt[i].st, vt[i].pa, vt[i].hi, vt[i].mi, vt[i].bt);
            chk($sformatf("vec%0d running", i), int'(Running), vt[i].e_run);
            chk($sformatf("vec%0d serving", i), int'(Serving), vt[i].e_srv);
            chk($sformatf("vec%0d level", i), int'(Level), vt[i].e_lvl);
            chk($sformatf("vec%0d balldiv", i), int'(BallDiv), vt[i].e_div);
        end

        // Serve phase with a base tick every fourth clock.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset balltick", int'(BallTick), 0);
        chk("reset paddletick", int'(PaddleTick), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        btot = 0; ptot = 0; serve_drop = 0;
        for (int g = 0; g < SERVE_TICKS; g++) begin
            if (Serving !== 1'b1) serve_drop++;
            grp(1'b0, bn, pn);
            btot += bn;
            ptot += pn;
        end
        chk("serve held 32 ticks", serve_drop, 0);
        chk("serve ball ticks", btot, 0);
        chk("serve paddle ticks", ptot, SERVE_TICKS / PADDLE_DIV);
        chk("running after serve", int'(Running), 1);
        groups_to_ball(n);
        chk("first ball step spacing", n, 16);

        // Four hits: new divisor applies only after the pending reload.
        hits(4);
        chk("level after 4 hits", int'(Level), 1);
        chk("div after 4 hits", int'(BallDiv), 14);
        groups_to_ball(n);
        chk("spacing before reload", n, 16);
        groups_to_ball(n);
        chk("spacing after reload", n, 14);

        // Pause with 7 left on the ball counter.
        for (int g = 0; g < 6; g++) grp(1'b0, bn, pn);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        btot = 0; ptot = 0;
        for (int g = 0; g < 20; g++) begin
            grp(1'b1, bn, pn);
            btot += bn;
            ptot += pn;
        end
        chk("paused ball ticks", btot, 0);
        chk("paused paddle ticks", ptot, 0);
        chk("paused running", int'(Running), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resumed running", int'(Running), 1);
        groups_to_ball(n);
        chk("spacing after pause", n, 8);

        // Divisor floor and level saturation.
        hits(36);
        chk("level after 40 hits", int'(Level), 10);
        chk("div after 40 hits", int'(BallDiv), 4);
        hits(24);
        chk("level after 64 hits", int'(Level), 15);
        chk("div after 64 hits", int'(BallDiv), 4);
        groups_to_ball(n);
        chk("spacing at floor pending", n, 14);
        groups_to_ball(n);
        chk("spacing at floor", n, 4);

        // Hit and Miss together at level 2 with a partial hit count.
        fast_to_run();
        chk("fast run", int'(Running), 1);
        hits(9);
        chk("level before miss", int'(Level), 2);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("hit+miss serving", int'(Serving), 1);
        chk("hit+miss level", int'(Level), 0);
        chk("hit+miss div", int'(BallDiv), 16);
        for (int k = 0; k < SERVE_TICKS; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hits(3);
        chk("hitcnt cleared 3 hits", int'(Level), 0);
        hits(1);
        chk("hitcnt cleared 4th hit", int'(Level), 1);

        // Reset in RUN on the base tick that would have stepped the ball.
        fast_to_run();
        for (int k = 0; k < BALL_DIV_INIT - 1; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst balltick", int'(BallTick), 0);
        chk("rst paddletick", int'(PaddleTick), 0);
        chk("rst running", int'(Running), 0);
        chk("rst serving", int'(Serving), 0);
        chk("rst level", int'(Level), 0);
        chk("rst balldiv", int'(BallDiv), 16);

        // Random traffic compared cycle by cycle with the model.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmp_model = 1'b1;
        begin
            logic pa_lvl;
            int   start_err;
            pa_lvl = 1'b0;
            for (int c = 0; c < 8000; c++) begin
                if ($urandom_range(99) < 3) pa_lvl = ~pa_lvl;
                start_err = errors;
                cyc($urandom_range(999) < 2,
                    $urandom_range(99) < 5,
                    pa_lvl,
                    $urandom_range(99) < 15,
                    $urandom_range(199) < 1,
                    $urandom_range(2) == 0);
                if ((c % 500) == 499)
                    $display("random window %0d: checks %0d errors %0d", c / 500, checks, errors);
            end
        end
        cmp_model = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
